// File: rtl/kw_map_load_ctrl.sv
// ---------------------------------------------------------------------------
// kw_map_load_ctrl
//
// Load sequencer for the kernel-weight (KW) map register array. It sits
// between the layer sequencer and the NUM_REGS KW map slots. Each slot is an
// 8:1 mux over the eight weight-memory read banks (Rd_data0..7), with a load
// enable and a local clear.
//
// One accepted start for a KxK kernel runs this sequence:
//   1. CLEAR : the slots the kernel does not use (index >= K*K) are cleared.
//   2. READ  : an 8-word-wide weight-memory beat is requested.
//   3. WAIT  : the bench of RD_LATENCY-1 cycles until that beat is valid.
//   4. LOAD  : every used slot whose word lies in that beat is loaded.
//   Steps 2-4 repeat for each beat, then DONE pulses for one cycle.
//
// Kernel word w sits at global position p = start_offset + w. Its beat is
// p >> 3 and its bank (the slot's mux select) is p[2:0]. Mux selects are
// programmed once per accepted start and held until the next accepted start,
// so they are stable across every LOAD of the operation.
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous active-high reset
//   start        in   one-cycle request, ignored unless idle
//   kernel_size  in   K (legal range 1..MAX_K), sampled on accepted start
//   base_addr    in   weight-memory address of the first beat
//   start_offset in   bank holding kernel word 0 in the first beat
//   rd_en        out  weight-memory read strobe
//   rd_addr      out  beat address being read (0 when not reading)
//   Reg_loads    out  per-slot load enable
//   Mux_Sel      out  per-slot bank select, slot i at [3i+2:3i]
//   Local_Reset  out  per-slot clear
//   busy         out  operation in progress (CLEAR through last LOAD)
//   done         out  one-cycle completion pulse
//   cfg_err      out  pulses with done when kernel_size was illegal
// ---------------------------------------------------------------------------
module kw_map_load_ctrl #(
  parameter int NUM_REGS   = 49,
  parameter int MAX_K      = 7,
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            kernel_size,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [2:0]            start_offset,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [NUM_REGS-1:0]   Reg_loads,
  output logic [3*NUM_REGS-1:0] Mux_Sel,
  output logic [NUM_REGS-1:0]   Local_Reset,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  // Global word position: large enough for the last word at the largest
  // offset (7 + NUM_REGS - 1) and for the beat-count rounding term.
  localparam int POS_W  = $clog2(NUM_REGS + 16);
  localparam int BEAT_W = POS_W - 3;
  localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [2:0] MAX_K_L = 3'(MAX_K);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_LOAD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            state_q;
  logic                  err_q;
  logic [POS_W-1:0]      n_q;         // K*K of the running operation
  logic [2:0]            off_q;
  logic [ADDR_W-1:0]     base_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [BEAT_W-1:0]     last_beat_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [3*NUM_REGS-1:0] mux_sel_q;

  // Values derived from the inputs at the moment a start is accepted.
  logic                  k_legal;
  logic [POS_W-1:0]      n_in;
  logic [POS_W-1:0]      beats_in;
  logic [3*NUM_REGS-1:0] sel_init;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    k_legal  = (kernel_size != 3'd0) && (kernel_size <= MAX_K_L);
    n_in     = POS_W'(kernel_size) * POS_W'(kernel_size);
    // ceil((start_offset + N) / 8)
    beats_in = (POS_W'(start_offset) + n_in + POS_W'(7)) >> 3;
    sel_init = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      logic [POS_W-1:0] pos;
      pos = POS_W'(start_offset) + POS_W'(i);
      if (POS_W'(i) < n_in) begin
        sel_init[3*i +: 3] = pos[2:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      err_q       <= 1'b0;
      n_q         <= '0;
      off_q       <= '0;
      base_q      <= '0;
      beat_q      <= '0;
      last_beat_q <= '0;
      wait_q      <= '0;
      mux_sel_q   <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments, so every register
      // samples the pre-edge values regardless of statement order.
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (k_legal) begin
              state_q     <= S_CLEAR;
              err_q       <= 1'b0;
              n_q         <= n_in;
              off_q       <= start_offset;
              base_q      <= base_addr;
              last_beat_q <= BEAT_W'(beats_in - POS_W'(1));
              // Selects become valid in CLEAR and stay put until the next
              // accepted start; an illegal request leaves them untouched.
              mux_sel_q   <= sel_init;
            end else begin
              state_q <= S_DONE;
              err_q   <= 1'b1;
            end
          end
        end

        S_CLEAR: begin
          beat_q  <= '0;
          state_q <= S_READ;
        end

        S_READ: begin
          wait_q  <= '0;
          state_q <= (RD_LATENCY == 1) ? S_LOAD : S_WAIT;
        end

        // RD_LATENCY-1 cycles between the read strobe and the load.
        S_WAIT: begin
          if (wait_q == WAIT_W'(RD_LATENCY - 2)) begin
            state_q <= S_LOAD;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end

        S_LOAD: begin
          if (beat_q == last_beat_q) begin
            state_q <= S_DONE;
          end else begin
            beat_q  <= beat_q + BEAT_W'(1);
            state_q <= S_READ;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from registered state only, never from start.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_en       = (state_q == S_READ);
    rd_addr     = rd_en ? (base_q + ADDR_W'(beat_q)) : '0;
    busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    done        = (state_q == S_DONE);
    cfg_err     = done && err_q;
    Mux_Sel     = mux_sel_q;
    Reg_loads   = '0;
    Local_Reset = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      logic [POS_W-1:0] slot;
      logic [POS_W-1:0] pos;
      slot = POS_W'(i);
      pos  = POS_W'(off_q) + slot;
      // Loads only touch slots < N and clears only slots >= N, and the two
      // happen in different states, so a slot never sees both at once.
      Reg_loads[i]   = (state_q == S_LOAD) && (slot < n_q) &&
                       (pos[POS_W-1:3] == beat_q);
      Local_Reset[i] = (state_q == S_CLEAR) && (slot >= n_q);
    end
  end

endmodule
